// File: rtl/selection_credit_rr_pkg.sv
// Shared types for the credit-based output selection stage: direction codes,
// one-hot port encodings in [local..west] order and the per-input FSM states.
package selection_credit_rr_pkg;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  localparam logic [4:0] PORT_LOCAL = 5'b10000;
  localparam logic [4:0] PORT_NORTH = 5'b01000;
  localparam logic [4:0] PORT_EAST  = 5'b00100;
  localparam logic [4:0] PORT_SOUTH = 5'b00010;
  localparam logic [4:0] PORT_WEST  = 5'b00001;

  // Direction code d lands on request bit d+1; local is never produced here.
  function automatic logic [4:0] dir2port(dir_e d);
    case (d)
      DIR_N:   return PORT_NORTH;
      DIR_E:   return PORT_EAST;
      DIR_S:   return PORT_SOUTH;
      default: return PORT_WEST;
    endcase
  endfunction

endpackage

// File: rtl/selection_credit_rr_pick.sv
// Combinational choice for one candidate list: highest downstream credit wins,
// ties at the maximum resolved by rr (0 = lowest list index, 1 = highest).
module selection_credit_rr_pick
  import selection_credit_rr_pkg::*;
#(
  parameter int M        = 3,
  parameter int CREDIT_W = 3
) (
  input  logic [0:M-1][1:0]         list,
  input  logic [0:3][CREDIT_W-1:0]  credit,
  input  logic                      rr,
  output dir_e                      dir,
  output logic                      tie
);

  logic [CREDIT_W-1:0] best;
  logic [CREDIT_W-1:0] c;
  int                  cnt;
  int                  sel;
  int                  nmax;

  always_comb begin
    best = '0;
    c    = '0;
    sel  = 0;
    nmax = 0;
    cnt  = int'(list[M-1]);
    if (cnt > M-1) cnt = M-1;
    for (int k = 0; k < M-1; k++) begin
      if (k < cnt) begin
        c = credit[list[k]];
        if (nmax == 0 || c > best) begin
          best = c;
          sel  = k;
          nmax = 1;
        end else if (c == best) begin
          nmax = nmax + 1;
          if (rr) sel = k;
        end
      end
    end
    dir = dir_e'(list[sel]);
    tie = (nmax > 1);
  end

endmodule

// File: rtl/selection_credit_rr.sv
// Per-input output selection: latch a candidate list, pick a direction by
// free credit with round-robin tie break, hold a one-hot request until grant.
module selection_credit_rr
  import selection_credit_rr_pkg::*;
#(
  parameter int N        = 5,
  parameter int M        = 3,
  parameter int CREDIT_W = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [0:N-1]                  i_select_neighbor,
  input  logic [0:N-1][0:M-1][1:0]      i_avail_directions,
  input  logic [0:3][CREDIT_W-1:0]      i_credit,
  input  logic [0:N-1]                  i_grant,
  output logic [0:N-1][0:4]             o_output_req,
  output logic [0:N-1]                  o_busy,
  output logic [0:N-1]                  o_error
);

  for (genvar g = 0; g < N; g++) begin : g_lane
    state_e     st;
    logic       rr;
    logic [4:0] req_q;
    logic       busy_q;
    logic       err_q;
    dir_e       pick_dir;
    logic       pick_tie;

    selection_credit_rr_pick #(.M(M), .CREDIT_W(CREDIT_W)) u_pick (
      .list   (i_avail_directions[g]),
      .credit (i_credit),
      .rr     (rr),
      .dir    (pick_dir),
      .tie    (pick_tie)
    );

    always_ff @(posedge clk) begin
      if (reset) begin
        st     <= ST_IDLE;
        rr     <= 1'b0;
        req_q  <= '0;
        busy_q <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        case (st)
          ST_IDLE: if (i_select_neighbor[g]) begin
            // An empty list is a routing fault: flag it, raise no request.
            if (i_avail_directions[g][M-1] == 2'd0) begin
              err_q <= 1'b1;
            end else begin
              req_q  <= dir2port(pick_dir);
              busy_q <= 1'b1;
              st     <= ST_REQ;
              if (pick_tie) rr <= ~rr;
            end
          end
          default: if (i_grant[g]) begin
            req_q  <= '0;
            busy_q <= 1'b0;
            st     <= ST_IDLE;
          end
        endcase
      end
    end

    assign o_output_req[g] = req_q;
    assign o_busy[g]       = busy_q;
    assign o_error[g]      = err_q;
  end

endmodule

// File: tb/tb_selection_credit_rr.sv
// Directed bench for selection_credit_rr with hand-computed expected requests.
module tb_selection_credit_rr;
  localparam int N = 5;
  localparam int M = 3;
  localparam int CREDIT_W = 3;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [0:N-1]             sel;
  logic [0:N-1][0:M-1][1:0] avail;
  logic [0:3][CREDIT_W-1:0] credit;
  logic [0:N-1]             grant;
  logic [0:N-1][0:4]        req;
  logic [0:N-1]             busy;
  logic [0:N-1]             err;

  int n_tests = 0;
  int n_fail  = 0;

  selection_credit_rr #(.N(N), .M(M), .CREDIT_W(CREDIT_W)) dut (
    .clk                (clk),
    .reset              (reset),
    .i_select_neighbor  (sel),
    .i_avail_directions (avail),
    .i_credit           (credit),
    .i_grant            (grant),
    .o_output_req       (req),
    .o_busy             (busy),
    .o_error            (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_list(input int p, input logic [1:0] d0, input logic [1:0] d1, input logic [1:0] cnt);
    avail[p][0] = d0;
    avail[p][1] = d1;
    avail[p][2] = cnt;
  endtask

  task automatic strobe(input int p);
    sel[p] = 1'b1;
    step();
    sel[p] = 1'b0;
  endtask

  task automatic do_grant(input int p);
    grant[p] = 1'b1;
    step();
    grant[p] = 1'b0;
  endtask

  logic [0:N-1][0:4] exp_req;

  initial begin
    reset = 1'b1; sel = '0; avail = '0; credit = '0; grant = '0;
    step(); step();
    reset = 1'b0;
    chk("reset_req",  32'(req),  32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err",  32'(err),  32'd0);

    // single candidate
    credit = {3'd4, 3'd4, 3'd4, 3'd4};
    set_list(1, 2'd1, 2'd0, 2'd1);
    strobe(1);
    chk("single_req",  32'(req[1]), 32'b00100);
    chk("single_busy", 32'(busy[1]), 32'd1);
    do_grant(1);
    chk("single_req_clr",  32'(req[1]), 32'd0);
    chk("single_busy_clr", 32'(busy[1]), 32'd0);

    // credit preference, then late credit change must not move the request
    credit = {3'd1, 3'd5, 3'd4, 3'd4};
    set_list(0, 2'd0, 2'd1, 2'd2);
    strobe(0);
    chk("credit_pref", 32'(req[0]), 32'b00100);
    credit = {3'd7, 3'd0, 3'd0, 3'd0};
    step();
    chk("credit_hold", 32'(req[0]), 32'b00100);
    do_grant(0);
    credit = {3'd2, 3'd2, 3'd2, 3'd2};
    strobe(0);
    chk("rr_unchanged", 32'(req[0]), 32'b01000);
    do_grant(0);

    // tie round-robin on input 2
    credit = {3'd3, 3'd3, 3'd3, 3'd3};
    set_list(2, 2'd0, 2'd3, 2'd2);
    for (int k = 0; k < 4; k++) begin
      strobe(2);
      chk($sformatf("tie_rr%0d", k), 32'(req[2]), (k % 2 == 0) ? 32'b01000 : 32'b00001);
      do_grant(2);
    end

    // strobe while busy is dropped
    set_list(3, 2'd2, 2'd0, 2'd1);
    strobe(3);
    chk("busy_first", 32'(req[3]), 32'b00010);
    chk("busy_flag",  32'(busy[3]), 32'd1);
    set_list(3, 2'd0, 2'd0, 2'd1);
    strobe(3);
    chk("busy_ignore", 32'(req[3]), 32'b00010);
    do_grant(3);
    chk("busy_clr", 32'(req[3]), 32'd0);
    step();
    chk("busy_not_stored", 32'(req[3]), 32'd0);
    chk("busy_idle",       32'(busy[3]), 32'd0);

    // count 0 error, then reset during a held request
    set_list(4, 2'd1, 2'd2, 2'd0);
    strobe(4);
    chk("cnt0_err",  32'(err[4]), 32'd1);
    chk("cnt0_req",  32'(req[4]), 32'd0);
    chk("cnt0_busy", 32'(busy[4]), 32'd0);
    set_list(4, 2'd3, 2'd0, 2'd1);
    strobe(4);
    chk("after_err_req", 32'(req[4]), 32'b00001);
    chk("err_sticky",    32'(err[4]), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_req",  32'(req),  32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err",  32'(err),  32'd0);

    // all inputs in parallel; input 4 count=3 clamps to 2
    credit = {3'd7, 3'd2, 3'd5, 3'd0};
    set_list(0, 2'd0, 2'd1, 2'd2);
    set_list(1, 2'd1, 2'd2, 2'd2);
    set_list(2, 2'd3, 2'd1, 2'd2);
    set_list(3, 2'd3, 2'd0, 2'd1);
    set_list(4, 2'd2, 2'd3, 2'd3);
    exp_req = {5'b01000, 5'b00010, 5'b00100, 5'b00001, 5'b00010};
    sel = '1;
    step();
    sel = '0;
    for (int p = 0; p < N; p++)
      chk($sformatf("par_req%0d", p), 32'(req[p]), 32'(exp_req[p]));
    chk("par_busy", 32'(busy), 32'b11111);
    do_grant(2);
    exp_req[2] = 5'b00000;
    for (int p = 0; p < N; p++)
      chk($sformatf("par_after%0d", p), 32'(req[p]), 32'(exp_req[p]));
    chk("par_busy_after", 32'(busy), 32'b11011);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/selection_credit_rr.md
# selection_credit_rr

Per-input-port output-selection stage sitting directly downstream of the odd-even routing stage. Each input port's candidate direction list is latched, one output direction is chosen by the downstream free-credit count, and a registered one-hot output request is held toward the switch allocator until granted. Ties are broken by a per-input round-robin bit. A busy flag tells the routing stage when a port cannot accept a new list.

## Interface
- N, 5: number of router ports (local, north, east, south, west).
- M, 3: entries per candidate list; entries 0..M-2 hold directions, entry M-1 holds the candidate count.
- CREDIT_W, 3: width of each neighbour free-credit count.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- i_select_neighbor  in  [0:N-1]  per-input "candidate list valid" strobe from routing.
- i_avail_directions  in  [0:N-1][0:M-1][1:0]  candidate lists; direction code 0=N, 1=E, 2=S, 3=W.
- i_credit  in  [0:3][CREDIT_W-1:0]  free buffer slots at the N, E, S, W neighbours, indexed by direction code.
- i_grant  in  [0:N-1]  switch-allocator grant per input, valid only while that input's request is up.
- o_output_req  out  [0:N-1][0:4]  one-hot request per input, bit order [local, north, east, south, west].
- o_busy  out  [0:N-1]  input is holding a request; routing must not strobe it.
- o_error  out  [0:N-1]  sticky; strobe received with count 0.

## Operation
- Per-input FSM, two states: IDLE, REQ. All N inputs are independent.
- IDLE with i_select_neighbor[i]=1:
  - Read count = i_avail_directions[i][M-1].
  - Clamp count to M-1.
  - Count 0: set o_error[i] and stay IDLE.
  - Count ≥1: evaluate candidates 0..count-1 and go to REQ.
- Choice rule:
  - Candidate with the largest i_credit wins.
  - If all candidates have equal credit (including all-zero), the tie is broken by rr[i]: rr=0 picks the lowest list index, rr=1 picks the highest tied list index.
  - rr[i] toggles only when a tie decided the choice.
  - A single candidate is taken unconditionally, and rr[i] is unchanged.
- Direction code d maps to the o_output_req bit d+1. Local bit 0 is never driven by this block.
- REQ: o_output_req[i] and o_busy[i] are held constant.
  - On i_grant[i]=1: clear both, return to IDLE.
- i_select_neighbor[i] while in REQ is ignored; the list is not stored.
- i_grant[i] while IDLE is ignored.
- Credits are sampled only in the strobe cycle. Later credit changes do not alter a held request.

## Timing
- Reset values: o_output_req all 0, o_busy all 0, o_error all 0, rr all 0, FSMs IDLE.
- Reset mid-REQ drops the request the next edge; no grant is required.
- Strobe at edge t → o_output_req/o_busy valid after edge t (one-cycle latency), registered outputs.
- Grant sampled at edge t → o_output_req/o_busy low after edge t. A new strobe can be accepted at edge t+1 at the earliest, giving a 2-cycle minimum per packet per input.
- o_busy is registered and equals (state==REQ); there is no combinational path from i_grant to o_busy.
- o_error sets after the offending edge and clears only by reset.

## Structure
- Shared package holds:
  - the direction enum (N/E/S/W = 0..3);
  - the one-hot port constants (LOCAL=5'b10000 … WEST=5'b00001 in [local..west] order);
  - the FSM state typedef.
- Sub-module selection_pick: purely combinational, one instance per input. Inputs are one candidate list, the 4 credits and rr. Outputs are the chosen direction and a tie flag.
- Top module holds the FSMs, the rr bits and the output registers in a generate loop over N.

## Test plan
- Single candidate: input 1 strobed with list {E, –, count=1} and credits all 4 → after 1 cycle o_output_req[1]=00100 and o_busy[1]=1; grant → both 0 next cycle.
- Credit preference: input 0 list {N, E, count=2}, credit N=1, E=5 → request 00100 (east); rr unchanged.
- Tie round-robin: input 2 list {N, W, count=2} with equal credits 3, four packets each granted → north, west, north, west (01000, 00001, 01000, 00001).
- Busy drop: strobe input 3 with {S}; while in REQ strobe again with {N}, then grant → the original south (00010) request is served; after the grant, o_output_req[3]=0 and the input returns to IDLE (the {N} list was never stored).
- Count 0 and reset: strobe with count=0 → o_error set, no request. Assert reset during a held request → all outputs 0 next edge, o_error cleared.
- Parallel inputs: all five inputs strobed in the same cycle with distinct lists → five independent correct requests; granting one clears only that input.
